// File: rtl/mem_rr_arbiter.sv
// Purpose  : round-robin arbiter that shares one single-port 1024x32 memory between NUM_REQ requesters.
// Latency  : accept to response is 3 cycles with a nominal memory, one command per 4 cycles; a missing m_ready ends in a forced error after TIMEOUT+2 cycles from m_valid.
// Backpress: one command in flight; req_ready is held low outside IDLE, and requesters that are not granted keep their command.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   req_valid/req_wr_rd     per-requester command valid and write(1)/read(0)
//   req_addr/req_wdata      packed per-requester address / write data
//   req_ready               one-hot accept, combinational in IDLE
//   rsp_valid               one-hot single-cycle response strobe
//   rsp_rdata/rsp_error     response data / error, qualified by rsp_valid
//   m_valid                 single-cycle memory command pulse
//   m_wr_rd/m_addr/m_wdata  latched command, held outside ISSUE
//   m_ready/m_rdata/m_error memory completion, data and error
//   busy                    high whenever the FSM is not in IDLE
module mem_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wr_rd,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_error,
  output logic                      m_valid,
  output logic                      m_wr_rd,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [31:0]               m_wdata,
  input  logic                      m_ready,
  input  logic [31:0]               m_rdata,
  input  logic                      m_error,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [7:0]     TO_LIM   = 8'(TIMEOUT);
  localparam logic [IDX_W:0] NUM_WIDE = (IDX_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic [7:0]       cnt;
  logic             wait_done;

  // Round-robin search: start at ptr, wrap modulo NUM_REQ, first valid wins.
  always_comb begin
    logic [IDX_W:0] sum;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= NUM_WIDE) sum = sum - NUM_WIDE;
      if (!grant_any && req_valid[sum[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = sum[IDX_W-1:0];
      end
    end
  end

  // m_ready wins over the timeout when both land in the same cycle.
  assign wait_done = m_ready || (cnt == TO_LIM);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state flops; req_ready is the only combinational
  // path and is forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == IDLE && grant_any && rst_n) req_ready = NUM_REQ'(1) << grant_idx;
    if (state == RESP)                       rsp_valid = NUM_REQ'(1) << winner;
    m_valid = (state == ISSUE);
    busy    = (state != IDLE);
  end

  // Command latch, pointer, timeout counter and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      winner    <= '0;
      cnt       <= '0;
      m_wr_rd   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            winner  <= grant_idx;
            ptr     <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            m_wr_rd <= req_wr_rd[grant_idx];
            m_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            m_wdata <= req_wdata[grant_idx*32 +: 32];
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (m_ready) begin
            rsp_error <= m_error;
            // Writes and failed reads return zero so stale bus data never leaks.
            rsp_rdata <= (!m_wr_rd && !m_error) ? m_rdata : 32'd0;
          end else if (cnt == TO_LIM) begin
            rsp_error <= 1'b1;
            rsp_rdata <= 32'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          rsp_rdata <= 32'd0;
          rsp_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
